// File: rtl/box_filter_stream.sv
//------------------------------------------------------------------------------
// Module      : box_filter_stream
// Description : Streaming 3x3 mean filter over raster pixels. The window is
//               built from two line buffers. Border pixels pass through raw.
//               Define BOX_FILTER_ROUND_EN to round the mean to nearest
//               instead of truncating it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module box_filter_stream #(
  parameter int DW      = 8,
  parameter int CH      = 3,
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  input  logic             iSOF,
  input  logic [CH*DW-1:0] iData,
  output logic             oValid,
  output logic             oSOF,
  output logic [CH*DW-1:0] oData
);

  localparam int c_pw = CH * DW;
  localparam int c_sw = DW + 4;
  localparam int c_cw = $clog2(LINE_W);
  localparam int c_rw = $clog2(FRAME_H);
  localparam int c_ww = $clog2(LINE_W + 2);

  localparam logic [c_cw-1:0] c_col_last  = c_cw'(LINE_W - 1);
  localparam logic [c_rw-1:0] c_row_last  = c_rw'(FRAME_H - 1);
  localparam logic [c_ww-1:0] c_warm_done = c_ww'(LINE_W + 1);

  // Input position, warm-up tracking and centre-pixel position
  logic [c_cw-1:0] col_q, col_d, pos_col, cen_col;
  logic [c_rw-1:0] row_q, row_d, pos_row, cen_row;
  logic [c_ww-1:0] warm_q, warm_d;
  logic            emit;
  logic            cen_border;

  always_comb begin
    pos_col = iSOF ? '0 : col_q;
    pos_row = iSOF ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    warm_d  = warm_q;
    emit    = 1'b0;
    if (iValid) begin
      if (pos_col == c_col_last) begin
        col_d = '0;
        row_d = (pos_row == c_row_last) ? '0 : pos_row + c_rw'(1);
      end else begin
        col_d = pos_col + c_cw'(1);
        row_d = pos_row;
      end
      if (iSOF) begin
        warm_d = c_ww'(1);
      end else if (warm_q == c_warm_done) begin
        emit = 1'b1;
      end else begin
        warm_d = warm_q + c_ww'(1);
      end
    end

    // The centre sits one line and one pixel behind the newest beat.
    if (pos_col == '0) begin
      cen_col = c_col_last;
      if (pos_row == '0) begin
        cen_row = c_row_last - c_rw'(1);
      end else if (pos_row == c_rw'(1)) begin
        cen_row = c_row_last;
      end else begin
        cen_row = pos_row - c_rw'(2);
      end
    end else begin
      cen_col = pos_col - c_cw'(1);
      cen_row = (pos_row == '0) ? c_row_last : pos_row - c_rw'(1);
    end
    cen_border = (cen_col == '0) || (cen_col == c_col_last) ||
                 (cen_row == '0) || (cen_row == c_row_last);
  end

  // Line buffers addressed by column, read-before-write
  logic [c_pw-1:0] lb1_mem_q [LINE_W];
  logic [c_pw-1:0] lb2_mem_q [LINE_W];
  logic [c_pw-1:0] lb1_rd;
  logic [c_pw-1:0] lb2_rd;

  assign lb1_rd = lb1_mem_q[pos_col];
  assign lb2_rd = lb2_mem_q[pos_col];

  always_ff @(posedge iCLK) begin
    if (iValid) begin
      lb1_mem_q[pos_col] <= iData;
      lb2_mem_q[pos_col] <= lb1_rd;
    end
  end

  // Window [row][col]: row 0 oldest line, col 2 newest column
  logic [c_pw-1:0] win_q [3][3];
  logic [c_pw-1:0] win_d [3][3];

  always_comb begin
    win_d = win_q;
    if (iValid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = iData;
    end
  end

  always_ff @(posedge iCLK) begin
    win_q <= win_d;
  end

  // Pipeline stage registers
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sof_q, s1_sof_d;
  logic                 s1_border_q, s1_border_d;
  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sof_q, s2_sof_d;
  logic                 s2_border_q, s2_border_d;
  logic [c_pw-1:0]      s2_centre_q, s2_centre_d;
  logic [CH*c_sw-1:0]   s2_sum_q, s2_sum_d;
  logic                 s3_valid_q, s3_valid_d;
  logic                 s3_sof_q, s3_sof_d;
  logic [c_pw-1:0]      s3_data_q, s3_data_d;
  logic [c_pw-1:0]      div_d;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [c_sw-1:0] tot;
    logic [c_sw-1:0] num;
    logic [DW-1:0]   quo;

    always_comb begin
      tot = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tot = tot + c_sw'(win_q[r][c][g*DW +: DW]);
        end
      end
    end

    assign s2_sum_d[g*c_sw +: c_sw] = tot;

`ifdef BOX_FILTER_ROUND_EN
    assign num = s2_sum_q[g*c_sw +: c_sw] + c_sw'(4);
`else
    assign num = s2_sum_q[g*c_sw +: c_sw];
`endif

    // 9 * (2^DW - 1) + 4 still fits c_sw bits, so the quotient fits DW bits.
    assign quo = DW'(num / c_sw'(9));
    assign div_d[g*DW +: DW] = s2_border_q ? s2_centre_q[g*DW +: DW] : quo;
  end

  always_comb begin
    s1_valid_d  = emit;
    s1_sof_d    = emit && (cen_col == '0) && (cen_row == '0);
    s1_border_d = cen_border;
    s2_valid_d  = s1_valid_q;
    s2_sof_d    = s1_sof_q;
    s2_border_d = s1_border_q;
    s2_centre_d = win_q[1][1];
    s3_valid_d  = s2_valid_q;
    s3_sof_d    = s2_sof_q;
    s3_data_d   = div_d;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col_q       <= '0;
      row_q       <= '0;
      warm_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_border_q <= 1'b0;
      s2_centre_q <= '0;
      s2_sum_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_sof_q    <= 1'b0;
      s3_data_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      warm_q      <= warm_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_border_q <= s1_border_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_border_q <= s2_border_d;
      s2_centre_q <= s2_centre_d;
      s2_sum_q    <= s2_sum_d;
      s3_valid_q  <= s3_valid_d;
      s3_sof_q    <= s3_sof_d;
      s3_data_q   <= s3_data_d;
    end
  end

  assign oValid = s3_valid_q;
  assign oSOF   = s3_sof_q;
  assign oData  = s3_data_q;

endmodule

`default_nettype wire

// File: tb/tb_box_filter_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_box_filter_stream
// Description : Self-checking bench for box_filter_stream (8x4 frames, RGB888).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_box_filter_stream;

  localparam int DW   = 8;
  localparam int CH   = 3;
  localparam int LW   = 8;
  localparam int FH   = 4;
  localparam int PW   = CH * DW;
  localparam int NPIX = LW * FH;
  localparam int NB   = NPIX + LW + 1;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          iRST, iValid, iSOF;
  logic [PW-1:0] iData;
  logic          oValid, oSOF;
  logic [PW-1:0] oData;

  always #5 clk = ~clk;

  box_filter_stream #(.DW(DW), .CH(CH), .LINE_W(LW), .FRAME_H(FH)) dut (
    .iCLK(clk), .iRST(iRST), .iValid(iValid), .iSOF(iSOF), .iData(iData),
    .oValid(oValid), .oSOF(oSOF), .oData(oData)
  );

  int checks = 0;
  int errors = 0;

  logic          st_rst [MAXC];
  logic          st_v   [MAXC];
  logic          st_sof [MAXC];
  logic [PW-1:0] st_d   [MAXC];
  logic          ob_v   [MAXC];
  logic          ob_sof [MAXC];
  logic [PW-1:0] ob_d   [MAXC];
  logic          ex_v   [MAXC];
  logic          ex_sof [MAXC];
  logic          ex_zero[MAXC];
  logic [PW-1:0] ex_d   [MAXC];
  int            fb     [MAXC];
  int            ncyc, ntot;
  logic [PW-1:0] hist[$];
  logic [PW-1:0] outs[$];

  function automatic logic [PW-1:0] splat(input int v);
    logic [PW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [PW-1:0] pix(input int kind, input int row, input int col);
    case (kind)
      0:       return splat(100);
      1:       return (row == 2 && col == 3) ? splat(255) : '0;
      2:       return (row == 1 && col == 1) ? splat(14) : '0;
      3:       return splat(255);
      4:       return splat(col);
      default: return PW'($urandom);
    endcase
  endfunction

  // Reference: output pixel k of the current stream is the mean of its
  // 3x3 neighbourhood in stream order, or the raw pixel on the frame border.
  function automatic logic [PW-1:0] ref_pixel(input int k);
    int row, col, sum;
    logic [PW-1:0] r, px;
    row = (k / LW) % FH;
    col = k % LW;
    if (row == 0 || row == FH-1 || col == 0 || col == LW-1) return hist[k];
    r = '0;
    for (int c = 0; c < CH; c++) begin
      sum = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          px = hist[k + dr*LW + dc];
          sum += int'(px[c*DW +: DW]);
        end
`ifdef BOX_FILTER_ROUND_EN
      sum += 4;
`endif
      r[c*DW +: DW] = DW'(sum / 9);
    end
    return r;
  endfunction

  task automatic start_stim();
    for (int t = 0; t < MAXC; t++) begin
      st_rst[t] = 1'b0; st_v[t] = 1'b0; st_sof[t] = 1'b0; st_d[t] = '0;
    end
    ncyc = 0;
    for (int i = 0; i < 2; i++) begin st_rst[ncyc] = 1'b1; ncyc++; end
    ncyc++;
  endtask

  task automatic add_beat(input logic v, input logic s, input logic [PW-1:0] d);
    st_v[ncyc] = v; st_sof[ncyc] = s; st_d[ncyc] = d; st_rst[ncyc] = 1'b0;
    ncyc++;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_beat(1'b0, 1'b0, '0);
  endtask

  task automatic add_frame(input int kind, input int gap, input int nb, input logic sof);
    for (int i = 0; i < nb; i++) begin
      fb[i] = ncyc;
      add_beat(1'b1, sof && (i == 0), pix(kind, (i / LW) % FH, i % LW));
      if (gap == 1) add_idle(1);
      else if (gap == 2) add_idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic build_model();
    for (int t = 0; t < MAXC; t++) begin
      ex_v[t] = 1'b0; ex_sof[t] = 1'b0; ex_zero[t] = 1'b0; ex_d[t] = '0;
    end
    hist.delete();
    for (int t = 0; t < ncyc; t++) begin
      if (st_rst[t]) begin
        hist.delete();
        for (int i = 1; i <= 3; i++) ex_v[t+i] = 1'b0;
        ex_zero[t+1] = 1'b1;
      end else if (st_v[t]) begin
        if (st_sof[t]) hist.delete();
        hist.push_back(st_d[t]);
        if (!st_sof[t] && hist.size() > LW + 1) begin
          int k;
          k = hist.size() - LW - 2;
          ex_v[t+3]   = 1'b1;
          ex_sof[t+3] = (k % NPIX == 0);
          ex_d[t+3]   = ref_pixel(k);
        end
      end
    end
  endtask

  task automatic run_stream();
    outs.delete();
    ntot = ncyc + 6;
    for (int t = 0; t < ntot; t++) begin
      @(posedge clk); #1;
      iRST = st_rst[t]; iValid = st_v[t]; iSOF = st_sof[t]; iData = st_d[t];
      @(negedge clk);
      ob_v[t] = oValid; ob_sof[t] = oSOF; ob_d[t] = oData;
      if (oValid === 1'b1) outs.push_back(oData);
    end
  endtask

  function automatic int first_valid(input int from);
    for (int t = from; t < ntot; t++) if (ob_v[t] === 1'b1) return t;
    return -1;
  endfunction

  task automatic test_reset();
    start_stim();
    add_idle(4);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || ob_sof[t] !== 1'b0 || ob_d[t] !== '0) begin
        errors++;
        $display("FAIL reset t=%0d valid=%b sof=%b data=%h expected valid=0 sof=0 data=0", t, ob_v[t], ob_sof[t], ob_d[t]);
      end
    end
  endtask

  task automatic test_constant();
    int fv;
    start_stim();
    add_frame(0, 0, NB, 1'b1);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || (ex_v[t] && (ob_d[t] !== ex_d[t] || ob_sof[t] !== ex_sof[t])) || (ex_zero[t] && (ob_d[t] !== '0 || ob_sof[t] !== 1'b0))) begin
        errors++;
        $display("FAIL constant t=%0d valid=%b sof=%b data=%h expected valid=%b sof=%b data=%h", t, ob_v[t], ob_sof[t], ob_d[t], ex_v[t], ex_sof[t], ex_d[t]);
      end
    end
    fv = first_valid(0);
    checks++;
    if (fv !== fb[LW+1] + 3) begin
      errors++; $display("FAIL constant_latency first_valid=%0d expected %0d", fv, fb[LW+1] + 3);
    end
    checks++;
    if (fv < 0 || ob_sof[fv] !== 1'b1) begin
      errors++; $display("FAIL constant_sof first output sof not set (cycle %0d)", fv);
    end
    checks++;
    if (outs.size() != NPIX) begin
      errors++; $display("FAIL constant_count got %0d expected %0d", outs.size(), NPIX);
    end
    foreach (outs[i]) begin
      checks++;
      if (outs[i] !== splat(100)) begin
        errors++; $display("FAIL constant_value k=%0d got %h expected %h", i, outs[i], splat(100));
      end
    end
  endtask

  task automatic test_impulse();
    int n28;
    start_stim();
    add_frame(1, 0, NB, 1'b1);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || (ex_v[t] && (ob_d[t] !== ex_d[t] || ob_sof[t] !== ex_sof[t])) || (ex_zero[t] && (ob_d[t] !== '0 || ob_sof[t] !== 1'b0))) begin
        errors++;
        $display("FAIL impulse t=%0d valid=%b sof=%b data=%h expected valid=%b sof=%b data=%h", t, ob_v[t], ob_sof[t], ob_d[t], ex_v[t], ex_sof[t], ex_d[t]);
      end
    end
    n28 = 0;
    foreach (outs[i]) if (outs[i] === splat(28)) n28++;
    checks++;
    if (n28 != 6 || outs.size() != NPIX) begin
      errors++; $display("FAIL impulse_count got %0d pixels of 28 in %0d outputs, expected 6 in %0d", n28, outs.size(), NPIX);
    end
    checks++;
    if (outs.size() > 2*LW + 3 && outs[2*LW+3] !== splat(28)) begin
      errors++; $display("FAIL impulse_centre got %h expected %h", outs[2*LW+3], splat(28));
    end
  endtask

  task automatic test_rounding();
    logic [PW-1:0] exp14;
`ifdef BOX_FILTER_ROUND_EN
    exp14 = splat(2);
`else
    exp14 = splat(1);
`endif
    start_stim();
    add_frame(2, 0, NB, 1'b1);
    add_frame(3, 0, NB, 1'b1);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || (ex_v[t] && (ob_d[t] !== ex_d[t] || ob_sof[t] !== ex_sof[t])) || (ex_zero[t] && (ob_d[t] !== '0 || ob_sof[t] !== 1'b0))) begin
        errors++;
        $display("FAIL rounding t=%0d valid=%b sof=%b data=%h expected valid=%b sof=%b data=%h", t, ob_v[t], ob_sof[t], ob_d[t], ex_v[t], ex_sof[t], ex_d[t]);
      end
    end
    // The second iSOF drops the first frame's unfinished tail.
    checks++;
    if (outs.size() != NPIX + NB - LW - 1 || outs[LW+1] !== exp14) begin
      errors++; $display("FAIL round_14 got %h (%0d outputs) expected %h (%0d outputs)", outs[LW+1], outs.size(), exp14, NPIX + NB - LW - 1);
    end
    checks++;
    if (outs[outs.size() - NPIX + LW + 1] !== splat(255)) begin
      errors++; $display("FAIL round_255 got %h expected %h", outs[outs.size() - NPIX + LW + 1], splat(255));
    end
  endtask

  task automatic test_border();
    start_stim();
    add_frame(4, 0, NB, 1'b1);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || (ex_v[t] && (ob_d[t] !== ex_d[t] || ob_sof[t] !== ex_sof[t])) || (ex_zero[t] && (ob_d[t] !== '0 || ob_sof[t] !== 1'b0))) begin
        errors++;
        $display("FAIL border t=%0d valid=%b sof=%b data=%h expected valid=%b sof=%b data=%h", t, ob_v[t], ob_sof[t], ob_d[t], ex_v[t], ex_sof[t], ex_d[t]);
      end
    end
    foreach (outs[i]) begin
      checks++;
      if (outs[i] !== splat(i % LW)) begin
        errors++; $display("FAIL border_ramp k=%0d got %h expected %h", i, outs[i], splat(i % LW));
      end
    end
  endtask

  task automatic test_gaps();
    start_stim();
    add_frame(0, 1, NB, 1'b1);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || (ex_v[t] && (ob_d[t] !== ex_d[t] || ob_sof[t] !== ex_sof[t])) || (ex_zero[t] && (ob_d[t] !== '0 || ob_sof[t] !== 1'b0))) begin
        errors++;
        $display("FAIL gaps t=%0d valid=%b sof=%b data=%h expected valid=%b sof=%b data=%h", t, ob_v[t], ob_sof[t], ob_d[t], ex_v[t], ex_sof[t], ex_d[t]);
      end
    end
    for (int i = LW + 1; i < NB; i++) begin
      checks++;
      if (ob_v[fb[i]+3] !== 1'b1 || ob_v[fb[i]+4] !== 1'b0 || ob_d[fb[i]+3] !== splat(100)) begin
        errors++; $display("FAIL gaps_pattern beat=%0d valid=%b,%b data=%h expected 1,0 %h", i, ob_v[fb[i]+3], ob_v[fb[i]+4], ob_d[fb[i]+3], splat(100));
      end
    end
    checks++;
    if (outs.size() != NPIX) begin
      errors++; $display("FAIL gaps_count got %0d expected %0d", outs.size(), NPIX);
    end
  endtask

  task automatic test_reset_mid();
    int rc, fv;
    start_stim();
    add_frame(0, 0, LW + 4, 1'b1);
    rc = ncyc;
    st_rst[ncyc] = 1'b1; ncyc++;
    add_idle(2);
    add_frame(5, 0, NB, 1'b1);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || (ex_v[t] && (ob_d[t] !== ex_d[t] || ob_sof[t] !== ex_sof[t])) || (ex_zero[t] && (ob_d[t] !== '0 || ob_sof[t] !== 1'b0))) begin
        errors++;
        $display("FAIL reset_mid t=%0d valid=%b sof=%b data=%h expected valid=%b sof=%b data=%h", t, ob_v[t], ob_sof[t], ob_d[t], ex_v[t], ex_sof[t], ex_d[t]);
      end
    end
    checks++;
    if (ob_v[rc+1] !== 1'b0 || ob_d[rc+1] !== '0) begin
      errors++; $display("FAIL reset_mid_clear valid=%b data=%h expected 0 0", ob_v[rc+1], ob_d[rc+1]);
    end
    fv = first_valid(rc + 1);
    checks++;
    if (fv !== fb[LW+1] + 3) begin
      errors++; $display("FAIL reset_mid_warmup first_valid=%0d expected %0d", fv, fb[LW+1] + 3);
    end
  endtask

  task automatic test_random();
    start_stim();
    add_frame(5, 2, 20, 1'b1);
    add_frame(5, 2, NB, 1'b1);
    build_model();
    run_stream();
    for (int t = 0; t < ntot; t++) begin
      checks++;
      if (ob_v[t] !== ex_v[t] || (ex_v[t] && (ob_d[t] !== ex_d[t] || ob_sof[t] !== ex_sof[t])) || (ex_zero[t] && (ob_d[t] !== '0 || ob_sof[t] !== 1'b0))) begin
        errors++;
        $display("FAIL random t=%0d valid=%b sof=%b data=%h expected valid=%b sof=%b data=%h", t, ob_v[t], ob_sof[t], ob_d[t], ex_v[t], ex_sof[t], ex_d[t]);
      end
    end
    checks++;
    if (outs.size() != 20 - LW - 1 + NPIX) begin
      errors++; $display("FAIL random_count got %0d expected %0d", outs.size(), 20 - LW - 1 + NPIX);
    end
  endtask

  initial begin
    iRST = 1'b1; iValid = 1'b0; iSOF = 1'b0; iData = '0;
    repeat (3) @(posedge clk);
    #1 iRST = 1'b0;
    test_reset();
    test_constant();
    test_impulse();
    test_rounding();
    test_border();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
